// File: rtl/hardware_conv_mac_pkg.sv
// Shared types and the round/saturate helper for the serial-tap convolution MAC.
package conv_pkg;

  typedef enum logic [1:0] {ACC, DRAIN, OUT} state_t;

  // Widest accumulator the helper handles; callers sign-extend into it.
  localparam int AS_W = 128;

  // Round half up, arithmetic shift by frac_w, then clamp (sat=1) or wrap.
  // Returns {r, ovf}; the caller keeps the low data_w bits of r.
  function automatic logic [AS_W:0] round_sat(input logic signed [AS_W-1:0] acc,
                                               input int unsigned data_w,
                                               input int unsigned frac_w,
                                               input bit sat);
    logic signed [AS_W-1:0] half, r, hi, lo;
    logic ovf;
    half = AS_W'(1);
    half = half <<< (frac_w - 1);
    r    = (acc + half) >>> frac_w;
    hi   = AS_W'(1);
    hi   = (hi <<< (data_w - 1)) - AS_W'(1);
    lo   = ~hi;
    ovf  = (r > hi) || (r < lo);
    if (sat && r > hi)      r = hi;
    else if (sat && r < lo) r = lo;
    return {r, ovf};
  endfunction

endpackage

// File: rtl/hardware_conv_mac_if.sv
// Sample, result and weight-config buses of the convolution MAC.
interface hardware_conv_mac_if #(
  parameter int DATA_W = 32,
  parameter int TW     = 4
);
  logic              s_valid, s_ready, s_last;
  logic [DATA_W-1:0] s_data;
  logic              m_valid, m_ready, m_ovf;
  logic [DATA_W-1:0] m_data;
  logic              cfg_we, cfg_err;
  logic [TW-1:0]     cfg_addr;
  logic [DATA_W-1:0] cfg_wdata;

  modport master (
    output s_valid, s_data, s_last, m_ready, cfg_we, cfg_addr, cfg_wdata,
    input  s_ready, m_valid, m_data, m_ovf, cfg_err
  );

  modport slave (
    input  s_valid, s_data, s_last, m_ready, cfg_we, cfg_addr, cfg_wdata,
    output s_ready, m_valid, m_data, m_ovf, cfg_err
  );
endinterface

// File: rtl/hardware_conv_mac_weight_rf.sv
// TAPS x DATA_W weight register file: one write port, one combinational read port.
module conv_weight_rf #(
  parameter int DATA_W = 32,
  parameter int TAPS   = 9,
  parameter int TW     = $clog2(TAPS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [TW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [TW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [TAPS-1:0][DATA_W-1:0] w_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q <= '0;
    end else begin
      for (int i = 0; i < TAPS; i++)
        if (we && waddr == TW'(i)) w_q[i] <= wdata;
    end
  end

  assign rdata = w_q[raddr];

endmodule

// File: rtl/hardware_conv_mac.sv
// Streaming serial-tap signed fixed-point convolution MAC: one sample per cycle,
// one rounded/saturated result per TAPS-sample window.
module hardware_conv_mac
  import conv_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int FRAC_W   = 16,
  parameter int TAPS     = 9,
  parameter int SATURATE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  hardware_conv_mac_if.slave bus,
  output logic               tap_err,
  output logic               busy
);

  localparam int TW    = $clog2(TAPS);
  localparam int PW    = 2 * DATA_W;
  localparam int ACC_W = 2 * DATA_W + $clog2(TAPS);

  state_t                   state, state_nxt;
  logic                     rdy_q;
  logic [TW-1:0]            tap_cnt;
  logic signed [PW-1:0]     p1;
  logic                     p_vld, p_first;
  logic signed [ACC_W-1:0]  acc, acc_nxt;
  logic signed [DATA_W-1:0] w_rd, res_data;
  logic [DATA_W-1:0]        w_raw;
  logic                     res_ovf, s_hs, m_hs, last_tap, addr_bad, w_ok;

  assign s_hs     = bus.s_valid & bus.s_ready;
  assign m_hs     = bus.m_valid & bus.m_ready;
  assign last_tap = tap_cnt == TW'(TAPS - 1);
  assign addr_bad = 32'(bus.cfg_addr) >= 32'(TAPS);
  assign busy     = (tap_cnt != '0) | p_vld | (state != ACC);
  // The first tap's handshake makes the block busy in that same cycle.
  assign w_ok     = bus.cfg_we & ~busy & ~s_hs & ~addr_bad;

  conv_weight_rf #(.DATA_W(DATA_W), .TAPS(TAPS), .TW(TW)) u_wrf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (w_ok),
    .waddr (bus.cfg_addr),
    .wdata (bus.cfg_wdata),
    .raddr (tap_cnt),
    .rdata (w_raw)
  );
  assign w_rd = w_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACC;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ACC:     if (s_hs && last_tap) state_nxt = DRAIN;
      DRAIN:   state_nxt = OUT;
      OUT:     if (bus.m_ready) state_nxt = ACC;
      default: state_nxt = ACC;
    endcase
  end

  always_comb begin
    bus.s_ready = rdy_q & (state == ACC);
    bus.m_valid = state == OUT;
  end

  // The first product of a window overwrites acc, so no separate clear is needed.
  assign acc_nxt = p_first ? ACC_W'(p1) : acc + ACC_W'(p1);
  assign {res_data, res_ovf} =
    (DATA_W + 1)'(round_sat(AS_W'(acc_nxt), DATA_W, FRAC_W, SATURATE != 0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q       <= 1'b0;
      tap_cnt     <= '0;
      p1          <= '0;
      p_vld       <= 1'b0;
      p_first     <= 1'b0;
      acc         <= '0;
      tap_err     <= 1'b0;
      bus.cfg_err <= 1'b0;
      bus.m_data  <= '0;
      bus.m_ovf   <= 1'b0;
    end else begin
      rdy_q       <= 1'b1;
      p_vld       <= s_hs;
      tap_err     <= s_hs & (bus.s_last != last_tap);
      bus.cfg_err <= bus.cfg_we & ~w_ok;
      if (s_hs) begin
        p1      <= PW'(signed'(bus.s_data)) * PW'(w_rd);
        p_first <= tap_cnt == '0;
        tap_cnt <= last_tap ? '0 : tap_cnt + 1'b1;
      end
      if (p_vld)     acc <= acc_nxt;
      else if (m_hs) acc <= '0;
      // DRAIN folds in the last product and registers the result for OUT.
      if (state == DRAIN) begin
        bus.m_data <= res_data;
        bus.m_ovf  <= res_ovf;
      end
    end
  end

endmodule

// File: tb/tb_hardware_conv_mac.sv
// Bench for hardware_conv_mac: directed table, corner sequences and random windows
// against an arithmetic reference model; SATURATE=1 and SATURATE=0 instances in lockstep.
module tb_hardware_conv_mac;
  localparam int DW = 32, FW = 16, NT = 9, TW = 4;

  typedef struct {
    string       nm;
    logic [31:0] w[NT];
    logic [31:0] s[NT];
    logic [32:0] e_sat, e_wrap;
  } vec_t;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  hardware_conv_mac_if #(.DATA_W(DW), .TW(TW)) b0 ();
  hardware_conv_mac_if #(.DATA_W(DW), .TW(TW)) b1 ();
  logic tap_err0, busy0, tap_err1, busy1;

  hardware_conv_mac #(.DATA_W(DW), .FRAC_W(FW), .TAPS(NT), .SATURATE(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(b0), .tap_err(tap_err0), .busy(busy0));
  hardware_conv_mac #(.DATA_W(DW), .FRAC_W(FW), .TAPS(NT), .SATURATE(0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .bus(b1), .tap_err(tap_err1), .busy(busy1));

  assign b1.s_valid   = b0.s_valid;
  assign b1.s_data    = b0.s_data;
  assign b1.s_last    = b0.s_last;
  assign b1.m_ready   = b0.m_ready;
  assign b1.cfg_we    = b0.cfg_we;
  assign b1.cfg_addr  = b0.cfg_addr;
  assign b1.cfg_wdata = b0.cfg_wdata;

  int n_pass = 0, n_tot = 0;
  int tap_err_cnt = 0, cfg_err_cnt = 0;
  vec_t tbl[4];
  logic [31:0] ones[NT], zw[NT], wcur[NT], sb[NT], rw[NT], rs[NT];

  always @(negedge clk) if (rst_n) begin
    if (tap_err0)   tap_err_cnt++;
    if (b0.cfg_err) cfg_err_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Reference: exact sum of products, then floor((sum + half) / 2^FW) and range handling.
  function automatic logic [32:0] model(input logic [31:0] w[NT], input logic [31:0] s[NT],
                                        input bit sat);
    logic signed [127:0] sum, q, fl, rem;
    logic ovf;
    sum = '0;
    for (int i = 0; i < NT; i++) sum += 128'(signed'(s[i])) * 128'(signed'(w[i]));
    q   = sum + 128'sd32768;
    fl  = q / 128'sd65536;
    rem = q % 128'sd65536;
    if (rem < 0) fl = fl - 128'sd1;
    ovf = (fl > 128'sd2147483647) || (fl < -128'sd2147483648);
    if (sat && fl > 128'sd2147483647)       fl = 128'sd2147483647;
    else if (sat && fl < -128'sd2147483648) fl = -128'sd2147483648;
    return {fl[31:0], ovf};
  endfunction

  function automatic logic [31:0] rnd_val();
    logic [31:0] ext[4];
    ext = '{32'h7FFFFFFF, 32'h80000000, 32'h00008000, 32'hFFFF8000};
    case ($urandom_range(0, 2))
      0:       return $urandom;
      1:       return $urandom_range(0, 32'h000FFFFF) - 32'h00080000;
      default: return ext[$urandom_range(0, 3)];
    endcase
  endfunction

  task automatic load_w(input logic [31:0] w[NT]);
    for (int i = 0; i < NT; i++) begin
      b0.cfg_we = 1'b1; b0.cfg_addr = TW'(i); b0.cfg_wdata = w[i];
      tick();
    end
    b0.cfg_we = 1'b0;
  endtask

  task automatic send_tap(input logic [31:0] d, input bit last);
    int n = 0;
    b0.s_valid = 1'b1; b0.s_data = d; b0.s_last = last;
    while (!b0.s_ready && n < 40) begin tick(); n++; end
    if (n == 40) chk("s_ready_timeout", 64'd0, 64'd1);
    tick();
    b0.s_valid = 1'b0; b0.s_last = 1'b0;
  endtask

  task automatic run_win(input logic [31:0] s[NT], input logic [NT-1:0] lastv, input bit gaps);
    for (int i = 0; i < NT; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      send_tap(s[i], lastv[i]);
    end
  endtask

  task automatic get_res(input string nm, input logic [32:0] e0, input logic [32:0] e1,
                         input int stall);
    int n = 0;
    while (!b0.m_valid && n < 40) begin tick(); n++; end
    chk({nm, "_valid"}, 64'(b0.m_valid & b1.m_valid), 64'd1);
    repeat (stall) tick();
    chk({nm, "_sat"}, 64'({b0.m_data, b0.m_ovf}), 64'(e0));
    chk({nm, "_wrap"}, 64'({b1.m_data, b1.m_ovf}), 64'(e1));
    b0.m_ready = 1'b1; tick(); b0.m_ready = 1'b0;
  endtask

  initial begin
    logic mv;
    int c0, t0, exp_te, n;
    logic [NT-1:0] lv;

    for (int i = 0; i < NT; i++) begin
      ones[i] = 32'h00010000; zw[i] = '0;
      tbl[0].w[i] = 32'((i + 1) << 16); tbl[0].s[i] = 32'h00010000;
      tbl[1].w[i] = '0;                 tbl[1].s[i] = '0;
      tbl[2].w[i] = 32'h00090000;       tbl[2].s[i] = 32'h75300000;
      tbl[3].w[i] = 32'h00090000;       tbl[3].s[i] = 32'h8AD00000;
    end
    tbl[1].w[0] = 32'hFFFE0000; tbl[1].w[1] = 32'h00008000;
    tbl[1].s[0] = 32'h00038000; tbl[1].s[1] = 32'h00000001;
    tbl[0].nm = "sum45";   tbl[0].e_sat = {32'h002D0000, 1'b0}; tbl[0].e_wrap = {32'h002D0000, 1'b0};
    tbl[1].nm = "round";   tbl[1].e_sat = {32'hFFF90001, 1'b0}; tbl[1].e_wrap = {32'hFFF90001, 1'b0};
    tbl[2].nm = "sat_pos"; tbl[2].e_sat = {32'h7FFFFFFF, 1'b1}; tbl[2].e_wrap = {32'h14300000, 1'b1};
    tbl[3].nm = "sat_neg"; tbl[3].e_sat = {32'h80000000, 1'b1}; tbl[3].e_wrap = {32'hEBD00000, 1'b1};

    b0.s_valid = 0; b0.s_data = '0; b0.s_last = 0; b0.m_ready = 0;
    b0.cfg_we = 0; b0.cfg_addr = '0; b0.cfg_wdata = '0;
    #1;
    chk("reset_outputs", 64'({b0.s_ready, b0.m_valid, b0.m_data, b0.m_ovf, b0.cfg_err,
                             tap_err0, busy0}), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    chk("ready_after_reset", 64'({b0.s_ready, busy0}), 64'b10);

    // Directed table: exact result and 2-cycle latency.
    for (int v = 0; v < 4; v++) begin
      load_w(tbl[v].w);
      run_win(tbl[v].s, 9'h100, 1'b0);
      mv = b0.m_valid;
      tick();
      chk({tbl[v].nm, "_latency"}, 64'({mv, b0.m_valid}), 64'b01);
      get_res(tbl[v].nm, tbl[v].e_sat, tbl[v].e_wrap, 0);
    end

    // Output back-pressure: result held, input blocked, pending sample not lost.
    load_w(tbl[0].w);
    for (int i = 0; i < NT; i++) sb[i] = $urandom_range(0, 32'h0003FFFF) - 32'h00020000;
    run_win(ones, 9'h100, 1'b0);
    tick(); tick();
    b0.s_valid = 1'b1; b0.s_data = sb[0];
    for (int i = 0; i < 5; i++) begin
      chk("stall_hold", 64'({b0.s_ready, b0.m_valid, b0.m_data, b0.m_ovf}),
          64'({1'b0, 1'b1, 32'h002D0000, 1'b0}));
      tick();
    end
    b0.m_ready = 1'b1; tick(); b0.m_ready = 1'b0;
    run_win(sb, 9'h100, 1'b0);
    get_res("after_stall", model(tbl[0].w, sb, 1'b1), model(tbl[0].w, sb, 1'b0), 0);

    // Dropped config writes and s_last mismatch.
    c0 = cfg_err_cnt; t0 = tap_err_cnt;
    b0.cfg_we = 1'b1; b0.cfg_addr = 4'd0; b0.cfg_wdata = 32'h77770000;
    send_tap(ones[0], 1'b0);
    b0.cfg_we = 1'b0;
    tick();
    chk("cfg_err_first_tap", 64'(cfg_err_cnt - c0), 64'd1);
    for (int i = 1; i < 4; i++) send_tap(ones[i], 1'b0);
    chk("busy_mid_window", 64'(busy0), 64'd1);
    c0 = cfg_err_cnt;
    b0.cfg_we = 1'b1; b0.cfg_addr = 4'd2; b0.cfg_wdata = 32'h00007777;
    tick(); b0.cfg_we = 1'b0; tick();
    chk("cfg_err_busy", 64'(cfg_err_cnt - c0), 64'd1);
    for (int i = 4; i < NT; i++) send_tap(ones[i], i == 4 || i == 8);
    get_res("early_last", {32'h002D0000, 1'b0}, {32'h002D0000, 1'b0}, 0);
    chk("tap_err_count", 64'(tap_err_cnt - t0), 64'd1);
    run_win(ones, 9'h100, 1'b0);
    get_res("weights_kept", {32'h002D0000, 1'b0}, {32'h002D0000, 1'b0}, 0);
    c0 = cfg_err_cnt;
    b0.cfg_we = 1'b1; b0.cfg_addr = 4'd9; b0.cfg_wdata = 32'h12345678;
    tick(); b0.cfg_we = 1'b0; tick();
    chk("cfg_err_addr", 64'(cfg_err_cnt - c0), 64'd1);
    c0 = cfg_err_cnt;
    b0.cfg_we = 1'b1; b0.cfg_addr = 4'd4; b0.cfg_wdata = '0;
    tick(); b0.cfg_we = 1'b0; tick();
    chk("cfg_ok_no_err", 64'(cfg_err_cnt - c0), 64'd0);
    run_win(ones, 9'h100, 1'b0);
    get_res("weight_update", {32'h00280000, 1'b0}, {32'h00280000, 1'b0}, 0);

    // Async reset mid-window.
    load_w(tbl[0].w);
    for (int i = 0; i < 4; i++) send_tap(ones[i], 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs", 64'({b0.s_ready, b0.m_valid, b0.m_data, b0.m_ovf, b0.cfg_err,
                                tap_err0, busy0}), 64'd0);
    tick();
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (b0.m_valid) n++; end
    chk("no_stale_valid", 64'(n), 64'd0);
    run_win(ones, 9'h100, 1'b0);
    get_res("weights_cleared", model(zw, ones, 1'b1), model(zw, ones, 1'b0), 0);
    load_w(tbl[0].w);
    run_win(ones, 9'h100, 1'b0);
    get_res("post_reset", {32'h002D0000, 1'b0}, {32'h002D0000, 1'b0}, 0);

    // Random windows with gaps, stalls and occasional s_last errors.
    for (int k = 0; k < 24; k++) begin
      exp_te = 0;
      for (int i = 0; i < NT; i++) begin
        rw[i] = rnd_val(); rs[i] = rnd_val();
        lv[i] = (i == NT - 1) ^ ($urandom_range(0, 9) == 0);
        if (lv[i] != (i == NT - 1)) exp_te++;
      end
      load_w(rw);
      t0 = tap_err_cnt;
      run_win(rs, lv, 1'b1);
      get_res("rand", model(rw, rs, 1'b1), model(rw, rs, 1'b0), $urandom_range(0, 3));
      chk("rand_tap_err", 64'(tap_err_cnt - t0), 64'(exp_te));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
